// File: rtl/oric_mem_pkg.sv
// Shared constants and state encoding for the Oric RAM arbiter slice.
package oric_mem_pkg;

  localparam int unsigned AddrWidth   = 16;
  localparam logic [7:0]  DefaultFill = 8'hFF;

  typedef logic state_t;
  localparam state_t CLEAR = 1'b0;
  localparam state_t RUN   = 1'b1;

endpackage

// File: rtl/oric_ram_arbiter_if.sv
// CPU, download and RAM-array signals of the arbiter, bundled with directional modports.
interface oric_ram_arbiter_if;
  import oric_mem_pkg::*;

  logic                 cpu_cs;
  logic                 cpu_we;
  logic [AddrWidth-1:0] cpu_addr;
  logic [7:0]           cpu_d;
  logic [7:0]           cpu_q;
  logic                 dl_wr;
  logic [24:0]          dl_addr;
  logic [7:0]           dl_data;
  logic                 ioctl_wait;
  logic                 dl_overrun;
  logic [15:0]          dl_bytes;
  logic [AddrWidth-1:0] mem_addr;
  logic [7:0]           mem_din;
  logic                 mem_we;
  logic [7:0]           mem_q;

  modport slave (
    input  cpu_cs, cpu_we, cpu_addr, cpu_d, dl_wr, dl_addr, dl_data, mem_q,
    output cpu_q, ioctl_wait, dl_overrun, dl_bytes, mem_addr, mem_din, mem_we
  );

  modport master (
    output cpu_cs, cpu_we, cpu_addr, cpu_d, dl_wr, dl_addr, dl_data, mem_q,
    input  cpu_q, ioctl_wait, dl_overrun, dl_bytes, mem_addr, mem_din, mem_we
  );

endinterface

// File: rtl/oric_dl_buffer.sv
// One-byte download buffer: range-checked capture, commit in CPU-idle cycles,
// sticky overrun flag and committed-byte counter.
module oric_dl_buffer
  import oric_mem_pkg::*;
#(
  parameter logic [15:0] DL_BASE = 16'h0000
) (
  input  logic                 clk_sys,
  input  logic                 RESET,
  input  logic                 run,
  input  logic                 cpu_cs,
  input  logic                 dl_wr,
  input  logic [24:0]          dl_addr,
  input  logic [7:0]           dl_data,
  output logic                 full,
  output logic                 commit,
  output logic [AddrWidth-1:0] buf_addr,
  output logic [7:0]           buf_data,
  output logic                 dl_overrun,
  output logic [15:0]          dl_bytes
);

  logic                 full_q;
  logic                 overrun_q;
  logic [15:0]          bytes_q;
  logic [AddrWidth-1:0] addr_q;
  logic [7:0]           data_q;
  logic [25:0]          dl_sum;
  logic                 in_range;
  logic                 capture;

  // One extra bit so offsets that run past the top of RAM are detected, not wrapped.
  assign dl_sum   = {1'b0, dl_addr} + {10'd0, DL_BASE};
  assign in_range = ~|dl_sum[25:16];
  assign capture  = run & dl_wr & ~full_q & in_range;
  assign commit   = run & full_q & ~cpu_cs;

  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      full_q    <= 1'b0;
      overrun_q <= 1'b0;
      bytes_q   <= 16'h0000;
    end else begin
      if (capture) begin
        full_q <= 1'b1;
      end else if (commit) begin
        full_q  <= 1'b0;
        bytes_q <= bytes_q + 16'd1;
      end
      if (run && dl_wr && full_q) begin
        overrun_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (capture) begin
      addr_q <= dl_sum[15:0];
      data_q <= dl_data;
    end
  end

  assign full       = full_q;
  assign buf_addr   = addr_q;
  assign buf_data   = data_q;
  assign dl_overrun = overrun_q;
  assign dl_bytes   = bytes_q;

endmodule

// File: rtl/oric_ram_arbiter.sv
// Shares the 64 KB RAM between the power-up clear engine, the CPU bus and the
// HPS download path; holds the core in reset until the clear finishes.
module oric_ram_arbiter
  import oric_mem_pkg::*;
#(
  parameter logic [7:0]  FILL    = DefaultFill,
  parameter logic [15:0] DL_BASE = 16'h0000
) (
  input  logic              clk_sys,
  input  logic              RESET,
  output logic              sys_reset,
  oric_ram_arbiter_if.slave bus
);

  state_t               state_q;
  logic [AddrWidth-1:0] clr_cnt_q;
  logic                 run;
  logic                 buf_full;
  logic                 buf_commit;
  logic [AddrWidth-1:0] buf_addr;
  logic [7:0]           buf_data;

  assign run = (state_q == RUN);

  always_ff @(posedge clk_sys) begin
    if (RESET) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
    end else if (state_q == CLEAR) begin
      clr_cnt_q <= clr_cnt_q + 1'b1;
      if (clr_cnt_q == {AddrWidth{1'b1}}) begin
        state_q <= RUN;
      end
    end
  end

  oric_dl_buffer #(
    .DL_BASE (DL_BASE)
  ) u_dl_buffer (
    .clk_sys    (clk_sys),
    .RESET      (RESET),
    .run        (run),
    .cpu_cs     (bus.cpu_cs),
    .dl_wr      (bus.dl_wr),
    .dl_addr    (bus.dl_addr),
    .dl_data    (bus.dl_data),
    .full       (buf_full),
    .commit     (buf_commit),
    .buf_addr   (buf_addr),
    .buf_data   (buf_data),
    .dl_overrun (bus.dl_overrun),
    .dl_bytes   (bus.dl_bytes)
  );

  // CPU always wins; a buffered download byte only uses otherwise idle cycles.
  always_comb begin
    bus.mem_addr = bus.cpu_addr;
    bus.mem_din  = bus.cpu_d;
    bus.mem_we   = 1'b0;
    if (!run) begin
      bus.mem_addr = clr_cnt_q;
      bus.mem_din  = FILL;
      bus.mem_we   = 1'b1;
    end else if (bus.cpu_cs) begin
      bus.mem_we = bus.cpu_we;
    end else if (buf_commit) begin
      bus.mem_addr = buf_addr;
      bus.mem_din  = buf_data;
      bus.mem_we   = 1'b1;
    end
  end

  assign sys_reset      = ~run;
  assign bus.ioctl_wait = ~run | buf_full;
  assign bus.cpu_q      = bus.mem_q;

endmodule
